spi_reg_ctrl: RTL
=================

# spi_reg_ctrl

Command sequencer between the SPI slave byte engine and an on-chip register bus. It parses each SPI frame (slave-select low) as one command byte followed by zero or more data bytes. It turns those bytes into single-cycle register write or read strobes, and it pre-loads read data into the byte engine's transmit register before the next byte starts shifting.

## Interface
Parameters:
- ADDR_W, 7, register address width; must be 1..7, taken from command bits [ADDR_W-1:0].
- STATUS_BYTE, 8'hA5, byte returned on MISO while the command byte is shifting.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- spi_ss  input  1  slave select, active-low, already synchronous to clk; high = frame inactive.
- spi_din  input  8  byte received from the byte engine.
- spi_done  input  1  one-cycle pulse: spi_din holds a new complete byte.
- spi_dout  output  8  registered byte for the byte engine to shift out next.
- reg_addr  output  ADDR_W  register bus address, registered.
- reg_wdata  output  8  write data, registered.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe.
- reg_rdata  input  8  read data; valid the cycle after reg_re.
- busy  output  1  high while a frame is active (state not IDLE).

## Operation
- Command byte format:
  - bit7 = 1 for read, 0 for write.
  - bits[ADDR_W-1:0] = start address.
  - Remaining bits are ignored.
- States: IDLE, CMD, WR_DATA, RD_FETCH, RD_WAIT, RD_DATA.
- IDLE:
  - spi_dout loaded with STATUS_BYTE.
  - spi_ss low -> CMD.
- CMD, on spi_done:
  - Latch the address into reg_addr.
  - bit7 = 0 -> WR_DATA.
  - bit7 = 1 -> RD_FETCH.
- WR_DATA, on spi_done:
  - reg_wdata <= spi_din and reg_we = 1 for one cycle at the current reg_addr.
  - Address update per Configuration (applied the cycle after reg_we).
  - Stays in WR_DATA.
- RD_FETCH: reg_re = 1 for one cycle -> RD_WAIT.
- RD_WAIT: spi_dout <= reg_rdata -> RD_DATA.
- RD_DATA, on spi_done:
  - Address update per Configuration.
  - -> RD_FETCH.
  - Received MOSI bytes are discarded.
- Frame end, from any state: spi_ss high -> IDLE next cycle.
  - No strobe is issued on or after the cycle spi_ss is sampled high.
  - reg_addr holds its last value.
- Simultaneous spi_done and spi_ss high: frame end wins; the byte is dropped and no write occurs.
- spi_done in RD_FETCH or RD_WAIT: the byte engine violated minimum byte spacing. The byte is ignored, the sequence completes, and spi_dout still updates.
- A frame with only a command byte performs no write. A read command does issue one read (prefetch).
- Address arithmetic is ADDR_W bits, unsigned, and wraps: address (2^ADDR_W)-1 + 1 = 0.

## Timing
- Reset values:
  - State IDLE.
  - spi_dout = STATUS_BYTE.
  - reg_addr = 0, reg_wdata = 0.
  - reg_we = 0, reg_re = 0, busy = 0.
- Write latency: reg_we asserts the cycle after spi_done, with reg_wdata/reg_addr valid in that same cycle.
- Read latency:
  - reg_re asserts the cycle after spi_done.
  - spi_dout is updated 2 cycles after reg_re (3 cycles after spi_done).
  - The byte engine needs at least 4 clk between spi_done and the first SCK edge of the next byte.
- reg_we and reg_re are never asserted together.
- busy rises the cycle after spi_ss goes low and falls the cycle after spi_ss goes high.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). Any strobe in progress is cut.

## Configuration
- SPI_REG_CTRL_AUTOINC_EN defined:
  - reg_addr increments by 1, with wrap, after each data byte (write) or each byte shifted out (read).
  - A burst touches consecutive registers.
- Not defined:
  - reg_addr is held for the whole frame.
  - Repeated writes go to the same address.
  - Repeated reads re-read the same address (FIFO-style polling).
  - The increment logic is absent.

## Structure
- Package spi_reg_ctrl_pkg holds:
  - The state enum type.
  - Localparam CMD_RD_BIT = 7.
  - The default STATUS_BYTE.
- No sub-module. The FSM, address register and output registers live in one module. The byte engine and the register bus are instantiated alongside it by the parent.

## Test plan
- Reset release with ss high -> spi_dout = 8'hA5, busy = 0, no strobes.
- Write burst: frame with command 8'h05, data 8'h11, 8'h22 ->
  - With AUTOINC_EN: reg_we at addr 5 with 8'h11, then addr 6 with 8'h22.
  - Without: both writes at addr 5.
- Read burst: frame with command 8'h83, two dummy bytes, register model returns addr+8'h40 ->
  - spi_dout = 8'h43 three cycles after the command's spi_done.
  - Then 8'h44 with AUTOINC_EN, or 8'h43 again without.
- Wrap (AUTOINC_EN): command 8'h7F, two data bytes -> writes at addr 127 then addr 0.
- Abort: spi_done and spi_ss high in the same cycle during WR_DATA -> no reg_we; IDLE next cycle; spi_dout = 8'hA5.
- Asynchronous reset asserted in RD_WAIT -> all outputs go to reset values without waiting for a clock edge; the next frame behaves normally.

Source files
------------

// File: rtl/spi_reg_ctrl_pkg.sv
// Shared types and constants for the SPI command sequencer.
package spi_reg_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CMD      = 3'd1,
      ST_WR_DATA  = 3'd2,
      ST_RD_FETCH = 3'd3,
      ST_RD_WAIT  = 3'd4,
      ST_RD_DATA  = 3'd5
   } state_t;

   localparam int         CMD_RD_BIT      = 7;
   localparam logic [7:0] STATUS_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/spi_reg_ctrl.sv
// SPI frame to register-bus command sequencer.
// Optional address auto-increment is enabled by defining SPI_REG_CTRL_AUTOINC_EN.
module spi_reg_ctrl
   import spi_reg_ctrl_pkg::*;
#(
   parameter int         ADDR_W      = 7,
   parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_ss,
   input  logic [7:0]        spi_din,
   input  logic              spi_done,
   output logic [7:0]        spi_dout,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [7:0]        reg_rdata,
   output logic              busy
);

   state_t state_r;
   state_t state_nx_s;
   logic   addr_load_s;
   logic   addr_step_s;
   logic   we_set_s;
   logic   re_set_s;
   logic   dout_stat_s;
   logic   dout_rd_s;

   // Without auto-increment the address simply holds, so no adder is built.
   function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
`ifdef SPI_REG_CTRL_AUTOINC_EN
      return a + ADDR_W'(1);
`else
      return a;
`endif
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next state and per-cycle actions; frame end overrides everything.
   always_comb begin
      state_nx_s  = state_r;
      addr_load_s = 1'b0;
      addr_step_s = 1'b0;
      we_set_s    = 1'b0;
      dout_stat_s = (state_r == ST_IDLE);
      dout_rd_s   = 1'b0;
      if (spi_ss) begin
         state_nx_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_nx_s = ST_CMD;
            end
            ST_CMD: begin
               if (spi_done) begin
                  addr_load_s = 1'b1;
                  state_nx_s  = spi_din[CMD_RD_BIT] ? ST_RD_FETCH : ST_WR_DATA;
               end else begin
                  state_nx_s = ST_CMD;
               end
            end
            ST_WR_DATA: begin
               // The address advances the cycle after the write strobe.
               addr_step_s = reg_we;
               we_set_s    = spi_done;
               state_nx_s  = ST_WR_DATA;
            end
            ST_RD_FETCH: begin
               state_nx_s = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               dout_rd_s  = 1'b1;
               state_nx_s = ST_RD_DATA;
            end
            ST_RD_DATA: begin
               if (spi_done) begin
                  addr_step_s = 1'b1;
                  state_nx_s  = ST_RD_FETCH;
               end else begin
                  state_nx_s = ST_RD_DATA;
               end
            end
            default: begin
               state_nx_s = ST_IDLE;
            end
         endcase
      end
   end

   assign re_set_s = (state_nx_s == ST_RD_FETCH);

   // Registered outputs toward the byte engine and the register bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spi_dout  <= STATUS_BYTE;
         reg_addr  <= '0;
         reg_wdata <= 8'h00;
         reg_we    <= 1'b0;
         reg_re    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         reg_we <= we_set_s;
         reg_re <= re_set_s;
         busy   <= (state_nx_s != ST_IDLE);
         if (we_set_s) begin
            reg_wdata <= spi_din;
         end
         if (addr_load_s) begin
            reg_addr <= spi_din[ADDR_W-1:0];
         end else if (addr_step_s) begin
            reg_addr <= addr_next(reg_addr);
         end
         if (dout_stat_s) begin
            spi_dout <= STATUS_BYTE;
         end else if (dout_rd_s) begin
            spi_dout <= reg_rdata;
         end
      end
   end

endmodule
